// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bit counter width; a 2-bit operand still needs a 1-bit counter.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_ad.sv
// 1-bit full-adder cell shared by the serial sequencer; purely combinational.
module full_ad (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell, LSB-first, one bit per clock.
// Start/done handshake to the master; carry held in a flop between bits.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = cnt_w(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             co;

  full_ad u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .c  (carry),
    .s  (s),
    .co (co)
  );

  // Sum bits refill a_sr from the MSB as operand bits leave at the LSB, so
  // after WIDTH shifts a_sr holds the result without a separate register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= co;
          a_sr  <= {s, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= {s, a_sr[WIDTH-1:1]};
            cout  <= co;
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): table vectors plus
// hand-written sequences for ignored start, async reset and held start.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op, follow it to done, check latency, busy width, result and pulse width.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        input logic [W-1:0] es, input logic ec, input string tag);
    int n;
    int busy_cnt;
    @(negedge clk);
    a = xa; b = xb; cin = xc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) busy_cnt++;
    end while (!done && n < 20);
    chk({tag, " done_seen"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(n - 1), 32'(W));
    chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(W));
    chk({tag, " sum"}, 32'(sum), 32'(es));
    chk({tag, " cout"}, 32'(cout), 32'(ec));
    @(negedge clk);
    chk({tag, " done_width"}, 32'(done), 32'd0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
  } op_t;

  initial begin
    op_t q[$];
    op_t o;
    logic [W:0] exp;
    int dones;
    int accepted;
    int n;
    logic prev_done;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    tbl[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    tbl[6] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    tbl[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #3;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset sum", 32'(sum), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // T1-T3 and extra patterns
    for (int i = 0; i < 8; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, $sformatf("vec%0d", i));

    // T4: start re-pulsed mid-run is ignored
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4 busy_mid", 32'(busy), 32'd1);
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        chk("t4 sum", 32'(sum), 32'h96);
        chk("t4 cout", 32'(cout), 32'd0);
      end
    end
    chk("t4 done_count", 32'(dones), 32'd1);
    chk("t4 idle_after", 32'(busy), 32'd0);

    // T5: async reset in the middle of a run
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5 busy_before", 32'(busy), 32'd1);
    chk("t5 sum_before", 32'(sum), 32'h96);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 busy_rst", 32'(busy), 32'd0);
    chk("t5 done_rst", 32'(done), 32'd0);
    chk("t5 sum_rst", 32'(sum), 32'd0);
    chk("t5 cout_rst", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("t5 no_done_after", 32'(dones), 32'd0);
    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "t5 resume");

    // T6: start held high with changing operands; scoreboard against a+b+cin
    dones = 0;
    accepted = 0;
    prev_done = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 80; k++) begin
      if (done) begin
        chk("t6 done_pulse", 32'(prev_done), 32'd0);
        if (q.size() == 0) begin
          chk("t6 unexpected_done", 32'd1, 32'd0);
        end else begin
          o = q.pop_front();
          exp = (W + 1)'(o.a) + (W + 1)'(o.b) + (W + 1)'(o.cin);
          chk("t6 sum", 32'(sum), 32'(exp[W-1:0]));
          chk("t6 cout", 32'(cout), 32'(exp[W]));
        end
        dones++;
      end
      if (prev_done) chk("t6 b2b_busy", 32'(busy), 32'd1);
      prev_done = done;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      start = 1'b1;
      if (!busy) begin
        q.push_back('{a, b, cin});
        accepted++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      if (done) begin
        o = q.pop_front();
        exp = (W + 1)'(o.a) + (W + 1)'(o.b) + (W + 1)'(o.cin);
        chk("t6 drain_sum", 32'(sum), 32'(exp[W-1:0]));
        chk("t6 drain_cout", 32'(cout), 32'(exp[W]));
        dones++;
      end
      @(negedge clk);
      n++;
    end
    chk("t6 drained", 32'(q.size()), 32'd0);
    chk("t6 done_count", 32'(dones), 32'(accepted));
    chk("t6 accepted_min", 32'(accepted >= 8), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
